// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Two-port register-file writeback arbiter. It takes ALU and load-unit
// writeback requests and uses round-robin when both are valid. The winning
// request goes out as a registered RegFile write one cycle after its
// handshake.
//
// Optional feature: define WB_PORT_ARBITER_BYPASS_EN to add combinational
// forwarding of the in-flight write onto two register read ports.

module wb_port_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,

  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,

  input  logic        hold,

  output logic [4:0]  RD,
  output logic [31:0] RD_DATA,
  output logic        reg_write_enable,
  output logic        last_grant
`ifdef WB_PORT_ARBITER_BYPASS_EN
  ,
  input  logic [4:0]  R1,
  input  logic [4:0]  R2,
  input  logic [31:0] R1_rf,
  input  logic [31:0] R2_rf,
  output logic [31:0] R1_fwd,
  output logic [31:0] R2_fwd
`endif
);

  logic        grant_alu;
  logic        grant_lsu;
  logic        handshake;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  // Grant decision: reset and hold block everything. A lone requester always
  // wins. When both request, the one that did not win last time goes first.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && !hold) begin
      if (alu_valid && lsu_valid) begin
        grant_alu = last_grant;
        grant_lsu = !last_grant;
      end else begin
        grant_alu = alu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;
  assign handshake = grant_alu | grant_lsu;

  // Select the winner's payload; only meaningful when handshake is high
  always_comb begin
    win_rd   = alu_rd;
    win_data = alu_data;
    if (grant_lsu) begin
      win_rd   = lsu_rd;
      win_data = lsu_data;
    end
  end

  // Register the accepted request as next cycle's RegFile write; x0 is accepted but never written
  always_ff @(posedge clk) begin
    if (rst) begin
      RD               <= 5'd0;
      RD_DATA          <= 32'd0;
      reg_write_enable <= 1'b0;
      last_grant       <= 1'b1;
    end else if (handshake) begin
      RD               <= win_rd;
      RD_DATA          <= win_data;
      reg_write_enable <= (win_rd != 5'd0);
      last_grant       <= grant_lsu;
    end else begin
      reg_write_enable <= 1'b0;
    end
  end

`ifdef WB_PORT_ARBITER_BYPASS_EN
  // Forward the write being presented this cycle onto matching read ports (never for x0)
  always_comb begin
    R1_fwd = R1_rf;
    R2_fwd = R2_rf;
    if (reg_write_enable && (RD == R1) && (R1 != 5'd0)) begin
      R1_fwd = RD_DATA;
    end
    if (reg_write_enable && (RD == R2) && (R2 != 5'd0)) begin
      R2_fwd = RD_DATA;
    end
  end
`endif

`ifndef SYNTHESIS
  // The grant must never go to both requesters at once
  a_one_ready: assert property (@(posedge clk) !(alu_ready && lsu_ready));

  // A requester that is waiting must keep its request stable until it is granted
  a_alu_stable: assert property (@(posedge clk)
    (!rst && alu_valid && !alu_ready) |=>
      (rst || (alu_valid && $stable(alu_rd) && $stable(alu_data))));

  a_lsu_stable: assert property (@(posedge clk)
    (!rst && lsu_valid && !lsu_ready) |=>
      (rst || (lsu_valid && $stable(lsu_rd) && $stable(lsu_data))));
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: table-driven vectors plus hand-written
// reset-overlap and forwarding sequences.

module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        hold;
  logic [4:0]  RD;
  logic [31:0] RD_DATA;
  logic        reg_write_enable;
  logic        last_grant;
`ifdef WB_PORT_ARBITER_BYPASS_EN
  logic [4:0]  R1;
  logic [4:0]  R2;
  logic [31:0] R1_rf;
  logic [31:0] R2_rf;
  logic [31:0] R1_fwd;
  logic [31:0] R2_fwd;
`endif

  int checks = 0;
  int errors = 0;

  wb_port_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .alu_ready        (alu_ready),
    .lsu_valid        (lsu_valid),
    .lsu_rd           (lsu_rd),
    .lsu_data         (lsu_data),
    .lsu_ready        (lsu_ready),
    .hold             (hold),
    .RD               (RD),
    .RD_DATA          (RD_DATA),
    .reg_write_enable (reg_write_enable),
    .last_grant       (last_grant)
`ifdef WB_PORT_ARBITER_BYPASS_EN
    ,
    .R1               (R1),
    .R2               (R2),
    .R1_rf            (R1_rf),
    .R2_rf            (R2_rf),
    .R1_fwd           (R1_fwd),
    .R2_fwd           (R2_fwd)
`endif
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        exp_ar;
    logic        exp_lr;
    logic        exp_we;
    logic        chk_addr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_lg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int r, int h, int av, int ard, logic [31:0] adata,
                              int lv, int lrd, logic [31:0] ldata,
                              int ear, int elr, int ewe, int ca, int erd,
                              logic [31:0] edata, int elg);
    vec_t v;
    v.rst      = 1'(r);
    v.hold     = 1'(h);
    v.av       = 1'(av);
    v.ard      = 5'(ard);
    v.adata    = adata;
    v.lv       = 1'(lv);
    v.lrd      = 5'(lrd);
    v.ldata    = ldata;
    v.exp_ar   = 1'(ear);
    v.exp_lr   = 1'(elr);
    v.exp_we   = 1'(ewe);
    v.chk_addr = 1'(ca);
    v.exp_rd   = 5'(erd);
    v.exp_data = edata;
    v.exp_lg   = 1'(elg);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    hold      = v.hold;
    alu_valid = v.av;
    alu_rd    = v.ard;
    alu_data  = v.adata;
    lsu_valid = v.lv;
    lsu_rd    = v.lrd;
    lsu_data  = v.ldata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd9;
    alu_data  = 32'h99;
    lsu_valid = 1'b1;
    lsu_rd    = 5'd8;
    lsu_data  = 32'h88;
`ifdef WB_PORT_ARBITER_BYPASS_EN
    R1    = 5'd0;
    R2    = 5'd0;
    R1_rf = 32'd0;
    R2_rf = 32'd0;
`endif

    // Vector table: rst hold | alu v/rd/data | lsu v/rd/data | ready a/l | we chk_addr rd data | last_grant
    vecs.push_back(mk(0,0, 0,0,0,      0,0,0,            0,0, 0,1,0,0,        1));
    vecs.push_back(mk(0,0, 1,1,5,      0,0,0,            1,0, 1,1,1,5,        0));
    vecs.push_back(mk(0,0, 0,0,0,      0,0,0,            0,0, 0,1,1,5,        0));
    vecs.push_back(mk(1,0, 0,0,0,      0,0,0,            0,0, 0,1,0,0,        1));
    vecs.push_back(mk(0,0, 1,2,10,     1,3,7,            1,0, 1,1,2,10,       0));
    vecs.push_back(mk(0,0, 1,2,10,     1,3,7,            0,1, 1,1,3,7,        1));
    vecs.push_back(mk(0,0, 1,2,10,     1,3,7,            1,0, 1,1,2,10,       0));
    vecs.push_back(mk(0,0, 1,2,10,     1,3,7,            0,1, 1,1,3,7,        1));
    vecs.push_back(mk(0,0, 1,2,10,     0,0,0,            1,0, 1,1,2,10,       0));
    vecs.push_back(mk(0,0, 0,0,0,      1,0,32'hFFFFFFFF, 0,1, 0,0,0,0,        1));
    vecs.push_back(mk(0,0, 0,0,0,      0,0,0,            0,0, 0,0,0,0,        1));
    vecs.push_back(mk(0,1, 1,2,10,     1,3,7,            0,0, 0,0,0,0,        1));
    vecs.push_back(mk(0,1, 1,2,10,     1,3,7,            0,0, 0,0,0,0,        1));
    vecs.push_back(mk(0,1, 1,2,10,     1,3,7,            0,0, 0,0,0,0,        1));
    vecs.push_back(mk(0,0, 1,2,10,     1,3,7,            1,0, 1,1,2,10,       0));
    vecs.push_back(mk(0,0, 0,0,0,      1,3,7,            0,1, 1,1,3,7,        1));
    vecs.push_back(mk(0,0, 0,0,0,      0,0,0,            0,0, 0,1,3,7,        1));

    // Reset with both requesters asserted: no grants, reset values afterwards
    #2;
    checkOutput("rst_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_we", 32'(reg_write_enable), 32'd0);
    checkOutput("rst_rd", 32'(RD), 32'd0);
    checkOutput("rst_data", RD_DATA, 32'd0);
    checkOutput("rst_last_grant", 32'(last_grant), 32'd1);

    // Table-driven vectors, one clock per row
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].exp_ar));
      checkOutput($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].exp_lr));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_we", i), 32'(reg_write_enable), 32'(vecs[i].exp_we));
      if (vecs[i].chk_addr) begin
        checkOutput($sformatf("v%0d_rd", i), 32'(RD), 32'(vecs[i].exp_rd));
        checkOutput($sformatf("v%0d_data", i), RD_DATA, vecs[i].exp_data);
      end
      checkOutput($sformatf("v%0d_last_grant", i), 32'(last_grant), 32'(vecs[i].exp_lg));
    end

    // Write registered just before reset is still presented; handshake under reset is dropped
    applyStimulus(mk(0,0, 1,7,32'h77, 0,0,0, 0,0,0,0,0,0,0));
    #2;
    checkOutput("pre_rst_alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(mk(1,0, 1,8,32'h88, 0,0,0, 0,0,0,0,0,0,0));
    #2;
    checkOutput("in_rst_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("in_rst_we", 32'(reg_write_enable), 32'd1);
    checkOutput("in_rst_rd", 32'(RD), 32'd7);
    checkOutput("in_rst_data", RD_DATA, 32'h77);
    @(posedge clk); #1;
    applyStimulus(mk(0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    checkOutput("post_rst_we", 32'(reg_write_enable), 32'd0);
    checkOutput("post_rst_rd", 32'(RD), 32'd0);
    checkOutput("post_rst_data", RD_DATA, 32'd0);
    checkOutput("post_rst_last_grant", 32'(last_grant), 32'd1);
    @(posedge clk); #1;
    checkOutput("post_rst_idle_we", 32'(reg_write_enable), 32'd0);

`ifdef WB_PORT_ARBITER_BYPASS_EN
    // Forwarding of the write currently presented onto the read ports
    applyStimulus(mk(0,0, 1,4,32'h1234, 0,0,0, 0,0,0,0,0,0,0));
    @(posedge clk); #1;
    applyStimulus(mk(0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
    R1    = 5'd4;
    R1_rf = 32'd0;
    R2    = 5'd0;
    R2_rf = 32'hABCD;
    #1;
    checkOutput("fwd_r1_hit", R1_fwd, 32'h1234);
    checkOutput("fwd_r2_x0", R2_fwd, 32'hABCD);
    R1    = 5'd5;
    R1_rf = 32'h55;
    #1;
    checkOutput("fwd_r1_miss", R1_fwd, 32'h55);
    @(posedge clk); #1;
    R1    = 5'd4;
    R1_rf = 32'h66;
    #1;
    checkOutput("fwd_r1_no_write", R1_fwd, 32'h66);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
